// File: rtl/text_cursor_ctrl.sv
// rtl/text_cursor_ctrl.sv - text-mode write cursor tracker with per-row line-length memory
// Optional bottom-row scrolling is enabled by defining TEXT_CURSOR_SCROLL_EN.
module text_cursor_ctrl #(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int XW   = 7,
    parameter int YW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          addflag,
    input  logic          enterflag,
    input  logic          bsflag,
    input  logic          clrflag,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          scroll,
    output logic          busy_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WIPE = 1'b1;

    localparam logic [XW-1:0] LAST_X = XW'(COLS - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(ROWS - 1);

    logic [0:0]    r_state;
    logic [YW-1:0] r_wipe_idx;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_scroll;
    logic          r_busy;
    logic [XW-1:0] r_linelen [ROWS];

    logic          w_advance;
    logic [YW-1:0] w_prev_y;

    // enterflag outranks addflag, so any non-add advance is a newline; both leave a row
    // whose length is simply the current column (an auto-wrap happens only at LAST_X).
    assign w_advance = enterflag || (addflag && (r_x == LAST_X));
    assign w_prev_y  = r_y - 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wipe_idx <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_scroll   <= 1'b0;
            r_busy     <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                r_linelen[i] <= '0;
            end
        end else begin
            r_scroll <= 1'b0;
            if (clrflag) begin
                r_x        <= '0;
                r_y        <= '0;
                r_state    <= S_WIPE;
                r_wipe_idx <= '0;
                r_busy     <= 1'b1;
            end else if (r_state == S_WIPE) begin
                r_linelen[r_wipe_idx] <= '0;
                if (r_wipe_idx == LAST_Y) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_wipe_idx <= r_wipe_idx + 1'b1;
                end
            end else if (bsflag) begin
                if (r_x != '0) begin
                    r_x <= r_x - 1'b1;
                end else if (r_y != '0) begin
                    r_y <= w_prev_y;
                    r_x <= r_linelen[w_prev_y];
                end
            end else if (enterflag || addflag) begin
                if (!w_advance) begin
                    r_x <= r_x + 1'b1;
                end else begin
                    r_x <= '0;
                    if (r_y != LAST_Y) begin
                        r_linelen[r_y] <= r_x;
                        r_y            <= r_y + 1'b1;
                    end else begin
`ifdef TEXT_CURSOR_SCROLL_EN
                        for (int i = 0; i < ROWS - 2; i++) begin
                            r_linelen[i] <= r_linelen[i+1];
                        end
                        r_linelen[ROWS-2] <= r_x;
                        r_linelen[ROWS-1] <= '0;
                        r_scroll          <= 1'b1;
`else
                        r_linelen[ROWS-1] <= r_x;
                        r_linelen[0]      <= '0;
                        r_y               <= '0;
`endif
                    end
                end
            end
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign scroll = r_scroll;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// tb/tb_text_cursor_ctrl.sv - randomized and directed bench for text_cursor_ctrl against a queue-based model
module tb_text_cursor_ctrl;

    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int XW   = 7;
    localparam int YW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          addflag = 1'b0;
    logic          enterflag = 1'b0;
    logic          bsflag = 1'b0;
    logic          clrflag = 1'b0;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          scroll;
    logic          busy_o;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: cursor position, line lengths as a queue, wipe progress
    int m_x, m_y, m_scroll, m_wipe;
    int m_len[$];

    always #5 clk = ~clk;

    text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) dut (
        .clk(clk), .rst(rst), .addflag(addflag), .enterflag(enterflag),
        .bsflag(bsflag), .clrflag(clrflag), .x(x), .y(y), .scroll(scroll), .busy_o(busy_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_x = 0; m_y = 0; m_scroll = 0; m_wipe = ROWS;
        m_len.delete();
        for (int i = 0; i < ROWS; i++) m_len.push_back(0);
    endfunction

    function automatic void model_new_row(input int len);
        if (m_y < ROWS - 1) begin
            m_len[m_y] = len;
            m_y++;
        end else begin
`ifdef TEXT_CURSOR_SCROLL_EN
            void'(m_len.pop_front());
            m_len[ROWS-2] = len;
            m_len.push_back(0);
            m_scroll = 1;
`else
            m_len[ROWS-1] = len;
            m_len[0] = 0;
            m_y = 0;
`endif
        end
    endfunction

    function automatic void model_step(input bit a, input bit e, input bit b, input bit c);
        m_scroll = 0;
        if (c) begin
            m_x = 0; m_y = 0; m_wipe = 0;
        end else if (m_wipe < ROWS) begin
            m_len[m_wipe] = 0;
            m_wipe++;
        end else if (b) begin
            if (m_x > 0) m_x--;
            else if (m_y > 0) begin
                m_y--;
                m_x = m_len[m_y];
            end
        end else if (e) begin
            int len = m_x;
            m_x = 0;
            model_new_row(len);
        end else if (a) begin
            if (m_x < COLS - 1) m_x++;
            else begin
                m_x = 0;
                model_new_row(COLS - 1);
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".x"}, 32'(x), 32'(m_x));
        check_val({tag, ".y"}, 32'(y), 32'(m_y));
        check_val({tag, ".scroll"}, 32'(scroll), 32'(m_scroll));
        check_val({tag, ".busy"}, 32'(busy_o), 32'(m_wipe < ROWS));
    endtask

    task automatic step(input string tag, input bit a, input bit e, input bit b, input bit c);
        @(negedge clk);
        addflag = a; enterflag = e; bsflag = b; clrflag = c;
        @(posedge clk);
        model_step(a, e, b, c);
        #1;
        check_outputs(tag);
    endtask

    task automatic repeat_step(input string tag, input int n, input bit a, input bit e, input bit b);
        for (int i = 0; i < n; i++) step(tag, a, e, b, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int budget = ROWS + 4;
        while (busy_o && budget > 0) begin
            step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
            budget--;
        end
        check_val({tag, ".idle_timeout"}, 32'(busy_o), 32'd0);
    endtask

    // reset asserted between clock edges; outputs must clear before the next edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        addflag = 0; enterflag = 0; bsflag = 0; clrflag = 0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int busy_cycles;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs("reset");
        @(negedge clk) rst = 1'b1;

        // 1: fill row 0, auto-wrap, backspace back to end of row 0
        repeat_step("p1_fill", COLS - 1, 1, 0, 0);
        check_val("p1_x_at_end", 32'(x), 32'(COLS - 1));
        step("p1_wrap", 1, 0, 0, 0);
        check_val("p1_wrap_y", 32'(y), 32'd1);
        step("p1_bs", 0, 0, 1, 0);
        check_val("p1_bs_x", 32'(x), 32'(COLS - 1));

        // 2: enter at (12,3), backspace twice
        step("p2_clr", 0, 0, 0, 1);
        wait_idle("p2_wipe");
        repeat_step("p2_rows", 3, 0, 1, 0);
        repeat_step("p2_cols", 12, 1, 0, 0);
        step("p2_enter", 0, 1, 0, 0);
        step("p2_bs1", 0, 0, 1, 0);
        check_val("p2_bs1_x", 32'(x), 32'd12);
        step("p2_bs2", 0, 0, 1, 0);
        check_val("p2_bs2_x", 32'(x), 32'd11);

        // 3: backspace at origin, and add+bs collision
        step("p3_clr", 0, 0, 0, 1);
        wait_idle("p3_wipe");
        step("p3_bs_origin", 0, 0, 1, 0);
        step("p3_add_bs", 1, 0, 1, 0);
        check_val("p3_x_origin", 32'(x), 32'd0);

        // 4: newline from bottom row
        repeat_step("p4_rows", ROWS - 1, 0, 1, 0);
        repeat_step("p4_cols", 5, 1, 0, 0);
        step("p4_enter", 0, 1, 0, 0);
        step("p4_after", 0, 0, 0, 0);
        step("p4_bs", 0, 0, 1, 0);

        // 5: clear mid-screen, adds ignored while busy, linelen[0] wiped
        repeat_step("p5_cols", 3, 1, 0, 0);
        step("p5_clr", 0, 0, 0, 1);
        busy_cycles = 0;
        for (int i = 0; i < ROWS + 2; i++) begin
            if (busy_o) busy_cycles++;
            step("p5_busy_add", 1, 0, 0, 0);
        end
        check_val("p5_busy_len", 32'(busy_cycles), 32'(ROWS));
        step("p5_enter", 0, 1, 0, 0);
        step("p5_bs", 0, 0, 1, 0);
        step("p5_bs0", 0, 0, 1, 0);

        // 6: async reset mid-wipe, then mid-count
        step("p6_clr", 0, 0, 0, 1);
        repeat_step("p6_wipe", 6, 0, 0, 0);
        async_reset("p6_rst_wipe");
        repeat_step("p6_rows", 2, 0, 1, 0);
        repeat_step("p6_cols", 33, 1, 0, 0);
        async_reset("p6_rst_count");

        // randomized traffic, weighted toward adds/enters so the bottom row is reached
        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 99);
            bit a = (r < 55) || ($urandom_range(0, 9) == 0);
            bit e = (r >= 55 && r < 75) || ($urandom_range(0, 15) == 0);
            bit b = (r >= 75 && r < 98) || ($urandom_range(0, 15) == 0);
            bit c = (r >= 98) && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 999) == 0) async_reset("rnd_rst");
            else step("rnd", a, e, b, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
